// File: rtl/frame_capture_sched.sv
// -----------------------------------------------------------------------------
// frame_capture_sched
//
// Frame-capture sequencer for the camera path. It watches iFVAL for frame
// boundaries and opens an output window (oFrame_En) over whole selected frames
// only. Frames are selected with a programmable decimation (iSkip frames
// skipped between captures), in single-shot or continuous sessions, and only
// when downstream reports iProc_Rdy. A frame that is due while downstream is
// busy is dropped and counted.
//
// Optional feature (compile-time macro FRAME_SCHED_TIMEOUT_EN):
//   When defined, ARM aborts to IDLE after TIMEOUT_CYC cycles without a
//   start-of-frame and raises the sticky oTimeout flag. When undefined, no
//   counter is built, oTimeout is tied low and ARM waits indefinitely.
//
// Ports:
//   iCLK        system clock, rising edge
//   iRST_N      asynchronous active-low reset
//   iFVAL       camera frame-valid (synchronous to iCLK)
//   iStart      1-cycle pulse, start a capture session (accepted in IDLE only)
//   iStop       1-cycle pulse, end the session (never truncates a frame)
//   iCont       1 = continuous session, 0 = single frame; sampled with iStart
//   iSkip       frames skipped before each capture; sampled with iStart
//   iProc_Rdy   downstream can accept a new frame
//   oFrame_En   high for the duration of the selected frame
//   oSOF/oEOF   1-cycle pulses at start/end of the selected frame
//   oBusy       high in any state except IDLE
//   oFrame_Cnt  captured frames (wraps)
//   oDrop_Cnt   frames dropped for iProc_Rdy=0 (saturates)
//   oState      IDLE=0, ARM=1, CAPTURE=2, WAIT_DONE=3
//   oTimeout    sticky start-of-frame timeout flag
// -----------------------------------------------------------------------------
module frame_capture_sched #(
  parameter int              SKIP_W      = 3,
  parameter int              FCNT_W      = 16,
  parameter int              TO_W        = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'd5000000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iFVAL,
  input  logic              iStart,
  input  logic              iStop,
  input  logic              iCont,
  input  logic [SKIP_W-1:0] iSkip,
  input  logic              iProc_Rdy,
  output logic              oFrame_En,
  output logic              oSOF,
  output logic              oEOF,
  output logic              oBusy,
  output logic [FCNT_W-1:0] oFrame_Cnt,
  output logic [FCNT_W-1:0] oDrop_Cnt,
  output logic [1:0]        oState,
  output logic              oTimeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    CAPTURE   = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Frame-boundary detection
  logic fval_q;
  logic rise, fall;

  // Session configuration and decimation
  logic              cont_lat;
  logic [SKIP_W-1:0] skip_lat;
  logic [SKIP_W-1:0] skip_cnt;
  logic              stop_pend;

  // One-cycle action strobes decoded by the FSM
  logic do_start;
  logic do_skip;
  logic do_capture;
  logic do_drop;
  logic do_done;
  logic do_timeout;
  logic to_hit;

  assign rise = iFVAL & ~fval_q;
  assign fall = ~iFVAL & fval_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its peers; blocking here would create ordering races.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and action decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_skip    = 1'b0;
    do_capture = 1'b0;
    do_drop    = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;

    case (state)
      IDLE: begin
        // Stop wins over a simultaneous start.
        if (iStart && !iStop) begin
          do_start  = 1'b1;
          state_nxt = ARM;
        end
      end

      ARM: begin
        // Only a rising edge seen while armed can select a frame, so a frame
        // already in progress on entry is never captured.
        if (iStop) begin
          state_nxt = IDLE;
        end else if (rise) begin
          if (skip_cnt < skip_lat) begin
            do_skip = 1'b1;
          end else if (iProc_Rdy) begin
            do_capture = 1'b1;
            state_nxt  = CAPTURE;
          end else begin
            // Due frame but downstream busy: count it and keep skip_cnt so
            // the very next frame is eligible.
            do_drop = 1'b1;
          end
        end else if (to_hit) begin
          do_timeout = 1'b1;
          state_nxt  = IDLE;
        end
      end

      CAPTURE: begin
        // iStop is only recorded here; the frame always runs to its end.
        if (fall) begin
          do_done   = 1'b1;
          state_nxt = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (iStop) begin
          state_nxt = IDLE;
        end else if (iProc_Rdy) begin
          state_nxt = (cont_lat && !stop_pend) ? ARM : IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Session configuration, decimation counter, pending stop
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_q    <= 1'b0;
      cont_lat  <= 1'b0;
      skip_lat  <= '0;
      skip_cnt  <= '0;
      stop_pend <= 1'b0;
    end else begin
      fval_q <= iFVAL;

      if (do_start) begin
        cont_lat <= iCont;
        skip_lat <= iSkip;
      end

      if (do_start || do_capture) begin
        skip_cnt <= '0;
      end else if (do_skip) begin
        skip_cnt <= skip_cnt + 1'b1;
      end

      if (state_nxt == IDLE) begin
        stop_pend <= 1'b0;
      end else if (state == CAPTURE && iStop) begin
        stop_pend <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  // The window is derived from the next state, so it opens on the edge that
  // samples the rising iFVAL and closes on the edge that samples it low.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oFrame_En  <= 1'b0;
      oSOF       <= 1'b0;
      oEOF       <= 1'b0;
      oBusy      <= 1'b0;
      oFrame_Cnt <= '0;
      oDrop_Cnt  <= '0;
    end else begin
      oFrame_En <= (state_nxt == CAPTURE);
      oSOF      <= do_capture;
      oEOF      <= do_done;
      oBusy     <= (state_nxt != IDLE);

      if (do_done) begin
        oFrame_Cnt <= oFrame_Cnt + 1'b1;
      end

      if (do_drop && (oDrop_Cnt != '1)) begin
        oDrop_Cnt <= oDrop_Cnt + 1'b1;
      end
    end
  end

  assign oState = state;

  // ---------------------------------------------------------------------------
  // Optional start-of-frame timeout
  // ---------------------------------------------------------------------------
`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - 1'b1;

  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;

  // The counter value equals the number of cycles spent in ARM since entry
  // (or since the last rise), so hitting TO_LAST ends ARM after exactly
  // TIMEOUT_CYC cycles.
  assign to_hit = (state == ARM) && (to_cnt == TO_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state_nxt == ARM && state != ARM) || rise) begin
        to_cnt <= '0;
      end else if (state == ARM) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (do_start) begin
        timeout_q <= 1'b0;
      end else if (do_timeout) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign oTimeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign to_hit             = 1'b0;
  assign oTimeout           = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

endmodule

// File: doc/frame_capture_sched.md
Name: frame_capture_sched

Overview:
- Sequencer for the camera frame-capture path in the IPU. It detects frame boundaries on iFVAL and selects whole frames only, with programmable decimation, single-shot or continuous modes.
- Its output window oFrame_En gates the downstream capture/processing datapath.
- Frame selection is handshaked against downstream readiness. Frames arriving while downstream is not ready are dropped and counted.

Parameters:
- SKIP_W, 3: width of the decimation value (frames skipped between captures).
- FCNT_W, 16: width of the captured-frame and dropped-frame counters.
- TO_W, 24: width of the start-of-frame timeout counter (used only with the optional feature).
- TIMEOUT_CYC, 24'd5000000: cycles allowed in ARM without a start-of-frame (used only with the optional feature).

Ports:
- iCLK  input  1  system clock; all logic on rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iFVAL  input  1  camera frame-valid, synchronous to iCLK.
- iStart  input  1  1-cycle pulse; start capture session.
- iStop  input  1  1-cycle pulse; end session.
- iCont  input  1  1 = continuous session, 0 = single frame; sampled with iStart.
- iSkip  input  SKIP_W  frames to skip before each capture; sampled with iStart.
- iProc_Rdy  input  1  downstream able to accept a new frame.
- oFrame_En  output  1  high for the duration of the selected frame.
- oSOF  output  1  1-cycle pulse at start of selected frame.
- oEOF  output  1  1-cycle pulse at end of selected frame.
- oBusy  output  1  high in any state except IDLE.
- oFrame_Cnt  output  FCNT_W  captured frames; wraps.
- oDrop_Cnt  output  FCNT_W  frames dropped for iProc_Rdy=0; saturates at all-ones.
- oState  output  2  IDLE=0, ARM=1, CAPTURE=2, WAIT_DONE=3.
- oTimeout  output  1  sticky start-of-frame timeout flag.

Behaviour:
- Reset (iRST_N=0, asynchronous): state IDLE, all outputs 0, internal regs 0. Applies immediately, including mid-frame.
- fval_q <= iFVAL each cycle.
  - rise = iFVAL & ~fval_q.
  - fall = ~iFVAL & fval_q.
- All outputs are registered.
- IDLE: on iStart (and no iStop the same cycle), latch iCont and iSkip, clear skip_cnt, go ARM. iStop wins over a simultaneous iStart.
- ARM: wait for rise. A frame already in progress on entry is never captured.
  - On rise with skip_cnt < skip_lat: skip_cnt++, stay ARM.
  - On rise with skip_cnt == skip_lat and iProc_Rdy=1: go CAPTURE, skip_cnt <= 0. On the same edge, oFrame_En <= 1 and oSOF pulses for 1 cycle.
  - On rise with skip_cnt == skip_lat and iProc_Rdy=0: oDrop_Cnt++ (saturating), stay ARM, skip_cnt holds. The next rise is eligible.
- CAPTURE: oFrame_En held 1.
  - On fall: oFrame_En <= 0, oEOF pulses, oFrame_Cnt++ (wrapping), go WAIT_DONE.
  - oFrame_En rises 1 cycle after iFVAL is first sampled high and falls 1 cycle after iFVAL is first sampled low.
- WAIT_DONE: when iProc_Rdy=1, go ARM if cont_lat=1 and no stop is pending; otherwise go IDLE.
- iStop handling:
  - In ARM or WAIT_DONE: go IDLE next cycle.
  - In CAPTURE: set stop_pend. The frame completes normally (no truncation), then WAIT_DONE exits to IDLE.
  - stop_pend is cleared on entering IDLE.
- iStart outside IDLE is ignored; latched cont/skip are unchanged.
- iSkip=0 selects every frame. The maximum value skips 2^SKIP_W-1 frames between captures.
- A 1-cycle iFVAL pulse still yields one CAPTURE cycle, then a normal EOF.

Optional Feature:
- Macro: FRAME_SCHED_TIMEOUT_EN.
- Defined:
  - A TO_W counter clears on entry to ARM and on every rise, and increments each cycle while in ARM.
  - When it reaches TIMEOUT_CYC-1: set oTimeout (sticky) and go IDLE.
  - oTimeout is cleared by an accepted iStart or by reset.
- Undefined: no counter is built, oTimeout is tied 0, and ARM waits indefinitely.

Test Plan:
- Reset mid-CAPTURE: iRST_N low for 1 cycle while oFrame_En=1 -> all outputs 0 immediately; state IDLE; no oEOF.
- Single shot, iSkip=0, iCont=0, iProc_Rdy=1, 3 frames of 100 cycles -> exactly one oFrame_En window of 100 cycles, delayed 1 cycle from iFVAL; oFrame_Cnt=1; ends in IDLE.
- Continuous, iSkip=2, 9 frames -> frames 3, 6, 9 captured; oFrame_Cnt=3; oSOF/oEOF 3 pulses each.
- iStart mid-frame, then iProc_Rdy=0 at the next rise -> partial frame ignored; oDrop_Cnt=1; the following frame is captured once iProc_Rdy=1.
- iStop at cycle 50 of a 100-cycle captured frame -> oFrame_En stays high for the full 100 cycles, then IDLE; no further capture.
- With FRAME_SCHED_TIMEOUT_EN and TIMEOUT_CYC=200, iStart with iFVAL held low -> oTimeout=1 exactly 200 cycles after ARM entry; state IDLE; next iStart clears oTimeout.
